// File: rtl/vote_pkg.sv
// Shared encodings and default widths for the ballot collector and the vote tally stage.
package vote_pkg;

    localparam int unsigned NP_W  = 32;
    localparam int unsigned VIP_W = 8;

    typedef enum logic [1:0] {
        CLS_NP   = 2'd0,
        CLS_VIP  = 2'd1,
        CLS_VVIP = 2'd2,
        CLS_BAD  = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/ballot_decode.sv
// Combinational ballot decoder: turns class/id into one-hot write enables per vector
// plus a legal flag (out-of-range ids and the illegal class yield no enable).
module ballot_decode #(
    parameter int unsigned NP_W  = vote_pkg::NP_W,
    parameter int unsigned VIP_W = vote_pkg::VIP_W,
    parameter int unsigned ID_W  = 5
) (
    input  logic [1:0]       cls,
    input  logic [ID_W-1:0]  id,
    output logic [NP_W-1:0]  np_we,
    output logic [VIP_W-1:0] vip_we,
    output logic             vvip_we,
    output logic             legal
);
    import vote_pkg::*;

    always_comb begin
        np_we   = '0;
        vip_we  = '0;
        vvip_we = 1'b0;
        legal   = 1'b0;
        unique case (cls)
            CLS_NP: begin
                if (32'(id) < NP_W) begin
                    np_we = NP_W'(1) << id;
                    legal = 1'b1;
                end
            end
            CLS_VIP: begin
                if (32'(id) < VIP_W) begin
                    vip_we = VIP_W'(1) << id;
                    legal  = 1'b1;
                end
            end
            CLS_VVIP: begin
                vvip_we = 1'b1;
                legal   = 1'b1;
            end
            CLS_BAD: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ballot_collector.sv
// Collects individual ballots into packed np/vip/vvip vectors and hands them to the
// tally stage with an out_valid/out_ready handshake once the session closes.
module ballot_collector #(
    parameter int unsigned NP_W  = vote_pkg::NP_W,
    parameter int unsigned VIP_W = vote_pkg::VIP_W,
    parameter int unsigned ID_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             open_i,
    input  logic             close_i,
    input  logic             ballot_valid,
    output logic             ballot_ready,
    input  logic [1:0]       ballot_class,
    input  logic [ID_W-1:0]  ballot_id,
    input  logic             ballot_yes,
    output logic [NP_W-1:0]  np,
    output logic [VIP_W-1:0] vip,
    output logic             vvip,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       cast_cnt,
    output logic             err,
    output logic             busy
);
    import vote_pkg::*;

    // Count value just before the last permitted ballot lands.
    localparam logic [5:0] LAST_PRE = 6'(NP_W + VIP_W);

    state_e           state;
    logic [NP_W-1:0]  np_cast;
    logic [VIP_W-1:0] vip_cast;
    logic             vvip_cast;

    logic [NP_W-1:0]  np_we;
    logic [VIP_W-1:0] vip_we;
    logic             vvip_we;
    logic             legal;
    logic             accept;
    logic             dup;
    logic             take;
    logic             drop;

    ballot_decode #(
        .NP_W  (NP_W),
        .VIP_W (VIP_W),
        .ID_W  (ID_W)
    ) u_decode (
        .cls     (ballot_class),
        .id      (ballot_id),
        .np_we   (np_we),
        .vip_we  (vip_we),
        .vvip_we (vvip_we),
        .legal   (legal)
    );

    assign accept = ballot_valid && ballot_ready;
    assign dup    = (|(np_we & np_cast)) || (|(vip_we & vip_cast)) || (vvip_we && vvip_cast);
    assign take   = accept && legal && !dup;
    assign drop   = accept && !(legal && !dup);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            np           <= '0;
            vip          <= '0;
            vvip         <= 1'b0;
            np_cast      <= '0;
            vip_cast     <= '0;
            vvip_cast    <= 1'b0;
            cast_cnt     <= '0;
            err          <= 1'b0;
            out_valid    <= 1'b0;
            ballot_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            err <= drop;
            case (state)
                S_IDLE: begin
                    if (open_i) begin
                        state        <= S_COLLECT;
                        np           <= '0;
                        vip          <= '0;
                        vvip         <= 1'b0;
                        np_cast      <= '0;
                        vip_cast     <= '0;
                        vvip_cast    <= 1'b0;
                        cast_cnt     <= '0;
                        ballot_ready <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (take) begin
                        np        <= (np & ~np_we) | (ballot_yes ? np_we : '0);
                        vip       <= (vip & ~vip_we) | (ballot_yes ? vip_we : '0);
                        vvip      <= vvip_we ? ballot_yes : vvip;
                        np_cast   <= np_cast | np_we;
                        vip_cast  <= vip_cast | vip_we;
                        vvip_cast <= vvip_cast | vvip_we;
                        cast_cnt  <= cast_cnt + 6'd1;
                    end
                    // A ballot arriving with close_i is still recorded before HOLD.
                    if (close_i || (take && cast_cnt == LAST_PRE)) begin
                        state        <= S_HOLD;
                        out_valid    <= 1'b1;
                        ballot_ready <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed, table-driven bench for ballot_collector plus hand sequences for
// auto-close and mid-session reset.
module tb_ballot_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        open_i, close_i, ballot_valid, ballot_yes, out_ready;
    logic [1:0]  ballot_class;
    logic [4:0]  ballot_id;
    logic        ballot_ready, vvip, out_valid, err, busy;
    logic [31:0] np;
    logic [7:0]  vip;
    logic [5:0]  cast_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ballot_collector #(
        .NP_W  (32),
        .VIP_W (8),
        .ID_W  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .open_i       (open_i),
        .close_i      (close_i),
        .ballot_valid (ballot_valid),
        .ballot_ready (ballot_ready),
        .ballot_class (ballot_class),
        .ballot_id    (ballot_id),
        .ballot_yes   (ballot_yes),
        .np           (np),
        .vip          (vip),
        .vvip         (vvip),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cast_cnt     (cast_cnt),
        .err          (err),
        .busy         (busy)
    );

    typedef struct packed {
        logic        open;
        logic        close;
        logic        valid;
        logic [1:0]  cls;
        logic [4:0]  id;
        logic        yes;
        logic        ordy;
        logic        e_ready;
        logic        e_err;
        logic        e_ov;
        logic        e_busy;
        logic [5:0]  e_cnt;
        logic [31:0] e_np;
        logic [7:0]  e_vip;
        logic        e_vvip;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic op, input logic cl, input logic v, input logic [1:0] c,
                         input logic [4:0] id, input logic y, input logic ordy);
        open_i       = op;
        close_i      = cl;
        ballot_valid = v;
        ballot_class = c;
        ballot_id    = id;
        ballot_yes   = y;
        out_ready    = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all(input string tag, input logic e_ready, input logic e_err,
                           input logic e_ov, input logic e_busy, input logic [5:0] e_cnt,
                           input logic [31:0] e_np, input logic [7:0] e_vip,
                           input logic e_vvip);
        chk({tag, ".ballot_ready"}, 32'(ballot_ready), 32'(e_ready));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".cast_cnt"}, 32'(cast_cnt), 32'(e_cnt));
        chk({tag, ".np"}, np, e_np);
        chk({tag, ".vip"}, 32'(vip), 32'(e_vip));
        chk({tag, ".vvip"}, 32'(vvip), 32'(e_vvip));
    endtask

    initial begin
        logic [7:0] pat;
        //           op    cl    v     cls   id     yes   ordy  rdy   err   ov    busy  cnt    np          vip    vvip
        // basic session: np3, vip0, vvip, close, handshake, then ignored close in IDLE
        vecs[0]  = '{1'b1,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b1,2'd0,5'd3, 1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd1, 32'h8,      8'h00,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,2'd1,5'd0, 1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd2, 32'h8,      8'h01,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b1,2'd2,5'd7, 1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd3, 32'h8,      8'h01,1'b1};
        vecs[4]  = '{1'b0,1'b1,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,6'd3, 32'h8,      8'h01,1'b1};
        vecs[5]  = '{1'b0,1'b1,1'b0,2'd0,5'd0, 1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,6'd3, 32'h8,      8'h01,1'b1};
        vecs[6]  = '{1'b0,1'b1,1'b1,2'd0,5'd1, 1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,6'd3, 32'h8,      8'h01,1'b1};
        // duplicate: first ballot wins; HOLD ignores ballots and open
        vecs[7]  = '{1'b1,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,2'd0,5'd5, 1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd1, 32'h20,     8'h00,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,2'd0,5'd5, 1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,6'd1, 32'h20,     8'h00,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd1, 32'h20,     8'h00,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,6'd1, 32'h20,     8'h00,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b1,2'd0,5'd1, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,6'd1, 32'h20,     8'h00,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,6'd1, 32'h20,     8'h00,1'b0};
        // out-of-range vip and illegal class are both dropped
        vecs[14] = '{1'b1,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[15] = '{1'b0,1'b0,1'b1,2'd1,5'd9, 1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[16] = '{1'b0,1'b0,1'b1,2'd3,5'd0, 1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[17] = '{1'b0,1'b1,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,6'd0, 32'h0,      8'h00,1'b0};
        // close together with a ballot: ballot is recorded, then HOLD
        vecs[19] = '{1'b1,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,6'd0, 32'h0,      8'h00,1'b0};
        vecs[20] = '{1'b0,1'b1,1'b1,2'd0,5'd0, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,6'd1, 32'h1,      8'h00,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b1,2'd0,5'd1, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,6'd1, 32'h1,      8'h00,1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,2'd0,5'd0, 1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,6'd1, 32'h1,      8'h00,1'b0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 8'h0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].open, vecs[i].close, vecs[i].valid, vecs[i].cls, vecs[i].id,
                  vecs[i].yes, vecs[i].ordy);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_err, vecs[i].e_ov,
                    vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_np, vecs[i].e_vip, vecs[i].e_vvip);
        end

        // Everyone votes: the 41st ballot closes the session on its own.
        pat = 8'b1010_1001;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 5'(i), 1'b1, 1'b0);
            step();
        end
        chk("full.np", np, 32'hffff_ffff);
        chk("full.cnt32", 32'(cast_cnt), 32'd32);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd1, 5'(i), pat[i], 1'b0);
            step();
        end
        chk_all("full.pre", 1'b1, 1'b0, 1'b0, 1'b1, 6'd40, 32'hffff_ffff, 8'b1010_1001, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'd2, 5'd0, 1'b1, 1'b0);
        step();
        chk_all("full.auto", 1'b0, 1'b0, 1'b1, 1'b1, 6'd41, 32'hffff_ffff, 8'b1010_1001, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1);
        step();
        chk("full.done.ov", 32'(out_valid), 32'd0);

        // Reset mid-COLLECT.
        drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 2'd0, 5'd2, 1'b1, 1'b0);
        step();
        chk("rst1.pre.np", np, 32'h4);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_all("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 8'h0, 1'b0);

        // Reset while out_valid waits on out_ready.
        drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 2'd1, 5'd4, 1'b1, 1'b0);
        step();
        chk("rst2.pre.ov", 32'(out_valid), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_all("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 8'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst2.idle%0d.ov", i), 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
